// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the gate sequencing checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_FINISH = 2'd2
  } gate_state_e;

  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;

  // Counter width able to hold DWELL-1, never narrower than one bit.
  function automatic int unsigned dwell_width(input int unsigned dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/gate_dwell_timer.sv
// Dwell counter: counts cycles a vector has been held; o_last flags the sample cycle.
module gate_dwell_timer
  import gate_chk_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last
);

  localparam int unsigned CW = dwell_width(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  // Count while enabled; clear has priority and is issued by the controller on each vector change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/gate_seq_checker.sv
// Sweeps a gate's operand bus through all input combinations and scores its output
// against a truth table, reporting pass/fail, mismatch count and first failing vector.
module gate_seq_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned           N_IN  = 2,
  parameter int unsigned           DWELL = 4,
  parameter logic [(1<<N_IN)-1:0]  TRUTH = TT_NOR2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            y_i,
  output logic [N_IN-1:0] vec_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_seen
);

  localparam logic [N_IN-1:0] VEC_MAX = '1;

  gate_state_e     r_state;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_err;
  logic [N_IN-1:0] r_first;
  logic            r_seen;

  logic            w_last;
  logic            w_mis;
  logic            w_clear;
  logic            w_enable;
  logic [N_IN:0]   w_err_nxt;

  assign w_mis     = (y_i != TRUTH[r_vec]);
  assign w_err_nxt = r_err + (N_IN+1)'(w_mis);

  // Timer is parked at zero outside DRIVE, so a fresh sweep always starts at count 0.
  assign w_clear  = (r_state != ST_DRIVE) || abort || w_last;
  assign w_enable = (r_state == ST_DRIVE);

  gate_dwell_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_last   (w_last)
  );

  // Sweep controller, vector counter and scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
      r_seen  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FINISH: begin
          if (start && !abort) begin
            r_err   <= '0;
            r_seen  <= 1'b0;
            r_first <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_vec   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            // Partial scoreboard is kept; a sample due this cycle is dropped.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_vec   <= '0;
          end else if (w_last) begin
            r_err <= w_err_nxt;
            if (w_mis && !r_seen) begin
              r_first <= r_vec;
              r_seen  <= 1'b1;
            end
            if (r_vec == VEC_MAX) begin
              r_state <= ST_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == '0);
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign vec_o      = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign first_fail = r_first;
  assign fail_seen  = r_seen;

endmodule

// File: tb/tb_gate_seq_checker.sv
// Randomized self-checking bench: two checker instances (2-input/DWELL 4 NOR and
// 3-input/DWELL 1 NOR3) driven by random gate truth tables, with random restarts and aborts.
module tb_gate_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_v;
  logic [1:0] abort_v;
  logic [3:0] g0;
  logic [7:0] g1;

  logic [1:0] vec0;
  logic       busy0, done0, pass0, fs0, y0;
  logic [2:0] err0;
  logic [1:0] ff0;

  logic [2:0] vec1;
  logic       busy1, done1, pass1, fs1, y1;
  logic [3:0] err1;
  logic [2:0] ff1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Gate under control is modelled as a lookup of its own truth table.
  assign y0 = g0[vec0];
  assign y1 = g1[vec1];

  gate_seq_checker #(
    .N_IN  (2),
    .DWELL (4),
    .TRUTH (4'b0001)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_v[0]),
    .abort      (abort_v[0]),
    .y_i        (y0),
    .vec_o      (vec0),
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .err_cnt    (err0),
    .first_fail (ff0),
    .fail_seen  (fs0)
  );

  gate_seq_checker #(
    .N_IN  (3),
    .DWELL (1),
    .TRUTH (8'b0000_0001)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_v[1]),
    .abort      (abort_v[1]),
    .y_i        (y1),
    .vec_o      (vec1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_cnt    (err1),
    .first_fail (ff1),
    .fail_seen  (fs1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input int s, input string tag, input int eb, input int ed,
                           input int ep, input int ev, input int ee, input int ef,
                           input int es);
    if (s == 0) begin
      chk($sformatf("%s.d0.busy", tag), 32'(busy0), 32'(eb));
      chk($sformatf("%s.d0.done", tag), 32'(done0), 32'(ed));
      chk($sformatf("%s.d0.pass", tag), 32'(pass0), 32'(ep));
      chk($sformatf("%s.d0.vec",  tag), 32'(vec0),  32'(ev));
      chk($sformatf("%s.d0.err",  tag), 32'(err0),  32'(ee));
      chk($sformatf("%s.d0.ff",   tag), 32'(ff0),   32'(ef));
      chk($sformatf("%s.d0.fs",   tag), 32'(fs0),   32'(es));
    end else begin
      chk($sformatf("%s.d1.busy", tag), 32'(busy1), 32'(eb));
      chk($sformatf("%s.d1.done", tag), 32'(done1), 32'(ed));
      chk($sformatf("%s.d1.pass", tag), 32'(pass1), 32'(ep));
      chk($sformatf("%s.d1.vec",  tag), 32'(vec1),  32'(ev));
      chk($sformatf("%s.d1.err",  tag), 32'(err1),  32'(ee));
      chk($sformatf("%s.d1.ff",   tag), 32'(ff1),   32'(ef));
      chk($sformatf("%s.d1.fs",   tag), 32'(fs1),   32'(es));
    end
  endtask

  // One sweep on instance s with gate table g. abort_at / restart_at are edge offsets
  // from the start edge (edge 0); -1 disables. Expected values come from the rule
  // "vector v is sampled at edge (v+1)*DWELL" applied to the mismatch set g ^ TRUTH.
  task automatic run_sweep(input int s, input logic [7:0] g, input int abort_at,
                           input int restart_at);
    int nv, d, last, lim, cnt, ff, fs;
    logic [7:0] mism;
    string tag;
    nv   = (s == 0) ? 4 : 8;
    d    = (s == 0) ? 4 : 1;
    last = nv * d;
    mism = g ^ 8'h01;
    tag  = $sformatf("sw%0d_g%02h", s, g);
    if (s == 0) g0 = g[3:0]; else g1 = g;
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    expect_st(s, {tag, ".go"}, 1, 0, 0, 0, 0, 0, 0);
    for (int e = 1; e <= last; e++) begin
      abort_v[s] = (e == abort_at);
      start_v[s] = (e == restart_at);
      tick();
      abort_v[s] = 1'b0;
      start_v[s] = 1'b0;
      lim = (e == abort_at) ? e - 1 : e;
      cnt = 0; ff = 0; fs = 0;
      for (int v = 0; v < nv; v++) begin
        if ((v + 1) * d <= lim && mism[v]) begin
          cnt++;
          if (fs == 0) begin ff = v; fs = 1; end
        end
      end
      if (e == abort_at) begin
        expect_st(s, $sformatf("%s.abort@%0d", tag, e), 0, 0, 0, 0, cnt, ff, fs);
        return;
      end else if (e == last) begin
        expect_st(s, {tag, ".done"}, 0, 1, (cnt == 0) ? 1 : 0, nv - 1, cnt, ff, fs);
      end else begin
        expect_st(s, $sformatf("%s.e%0d", tag, e), 1, 0, 0, e / d, cnt, ff, fs);
      end
    end
    // start+abort together after completion: abort wins, nothing changes.
    start_v[s] = 1'b1;
    abort_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    abort_v[s] = 1'b0;
    expect_st(s, {tag, ".hold"}, 0, 1, (cnt == 0) ? 1 : 0, nv - 1, cnt, ff, fs);
  endtask

  initial begin
    int s, lastn, ab, rs;
    logic [7:0] g;
    rst     = 1'b1;
    start_v = '0;
    abort_v = '0;
    g0      = '0;
    g1      = '0;
    #12;
    expect_st(0, "rst", 0, 0, 0, 0, 0, 0, 0);
    expect_st(1, "rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed: correct NOR with an ignored restart, NOT-a, OR, abort, NOR3.
    run_sweep(0, 8'h01, -1, 9);
    repeat (3) tick();
    run_sweep(0, 8'h01, -1, -1);
    run_sweep(0, 8'h03, -1, -1);
    run_sweep(0, 8'h0E, -1, -1);
    run_sweep(0, 8'h0E, 6, -1);
    run_sweep(1, 8'h01, -1, -1);

    // Asynchronous reset in the middle of a sweep.
    g0 = 4'b0110;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (10) tick();
    #3 rst = 1'b1;
    #1;
    expect_st(0, "midrst", 0, 0, 0, 0, 0, 0, 0);
    expect_st(1, "midrst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    expect_st(0, "postrst", 0, 0, 0, 0, 0, 0, 0);
    run_sweep(0, 8'h01, -1, -1);

    // Randomized sweeps.
    for (int i = 0; i < 30; i++) begin
      s     = int'($urandom_range(0, 1));
      g     = 8'($urandom);
      if (s == 0) g[7:4] = 4'h0;
      if ($urandom_range(0, 3) == 0) g = 8'h01;
      lastn = (s == 0) ? 16 : 8;
      ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lastn)) : -1;
      rs    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, lastn)) : -1;
      run_sweep(s, g, ab, rs);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
